// File: rtl/mp_ram_pkg.sv
// mp_ram_pkg: shared constants, byte-offset helper and response-pipe entry type
package mp_ram_pkg;
    localparam int PORT_W = 3;
    localparam int MAX_DW = 512;
    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
        logic [MAX_DW-1:0] data;
    } resp_t;
    function automatic int byte_off(input int dw);
        return $clog2(dw / 8);
    endfunction
endpackage

// File: rtl/mp_ram_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with one-hot grant and a pointer that moves past each winner
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] ptr, nxt;
    logic [N-1:0]  rot, low;
    always_comb begin
        rot = N'({req, req} >> ptr);
        low = rot & (~rot + N'(1));
        gnt = rst_n ? N'(({low, low} << ptr) >> N) : '0;
        nxt = ptr;
        for (int k = 0; k < N; k++)
            if (gnt[k]) nxt = PW'((k + 1) % N);
    end
    always_ff @(posedge clk)
        if (!rst_n) ptr <= '0;
        else ptr <= nxt;
endmodule

// File: rtl/mp_ram.sv
// mp_ram: multi-port byte-addressed RAM with round-robin arbitration and 1/2-cycle response pipe
module mp_ram
    import mp_ram_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_PORTS-1:0]                   req_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]                   we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
    output logic [NUM_PORTS-1:0]                   gnt_o,
    output logic [NUM_PORTS-1:0]                   rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o
);
    localparam int OFF = byte_off(DATA_WIDTH);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int MW  = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] NW = (ADDR_WIDTH + 1)'(NUM_WORDS);
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [NUM_PORTS-1:0]  gnt;
    logic [ADDR_WIDTH-1:0] addr, idx;
    logic                  we, hit;
    logic [DATA_WIDTH-1:0] wdata, rd;
    logic [NB-1:0]         be;
    logic [PORT_W-1:0]     port;
    logic [MW-1:0]         widx;
    resp_t                 s_new, last;
    rr_arbiter #(.N(NUM_PORTS)) u_arb (.clk(clk), .rst_n(rst_n), .req(req_i), .gnt(gnt));
    assign gnt_o = gnt;
    always_comb begin
        addr  = '0;
        we    = 1'b0;
        wdata = '0;
        be    = '0;
        port  = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            if (gnt[k]) begin
                addr  = addr_i[k];
                we    = we_i[k];
                wdata = wdata_i[k];
                be    = be_i[k];
                port  = PORT_W'(k);
            end
        idx         = addr >> OFF;
        hit         = {1'b0, idx} < NW;
        widx        = MW'(idx);
        rd          = hit ? mem[widx] : '0;
        s_new       = '0;
        s_new.valid = |gnt;
        s_new.port  = port;
        s_new.data  = MAX_DW'(rd);
    end
    // read-first: the response carries the word as it was before this access
    always_ff @(posedge clk)
        if (s_new.valid && we && hit)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
    if (READ_LATENCY == 2) begin : g_lat2
        resp_t s1;
        always_ff @(posedge clk)
            if (!rst_n) s1 <= '0;
            else s1 <= s_new;
        assign last = s1;
    end else begin : g_lat1
        assign last = s_new;
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            rvalid_o <= '0;
            rdata_o  <= '0;
        end else
            for (int k = 0; k < NUM_PORTS; k++) begin
                rvalid_o[k] <= last.valid && last.port == PORT_W'(k);
                if (last.valid && last.port == PORT_W'(k)) rdata_o[k] <= last.data[DATA_WIDTH-1:0];
            end
    if (DATA_WIDTH < MAX_DW) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^last.data[MAX_DW-1:DATA_WIDTH];
    end
endmodule

// File: tb/tb_mp_ram.sv
// tb_mp_ram: scoreboard bench driving a latency-1 and a latency-2 mp_ram with identical stimulus
module tb_mp_ram;
    localparam int AW = 12;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] we = '0;
    logic [1:0][AW-1:0] addr = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0][3:0] be = '0;
    logic [1:0] gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [1:0][31:0] rdata_a, rdata_b;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk;
    } ent_t;
    ent_t q[4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mp_ram #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_WORDS(256), .READ_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a));
    mp_ram #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_WORDS(256), .READ_LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b));

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    always @(negedge clk)
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                logic v;
                logic [31:0] r;
                ent_t e;
                v = d ? rvalid_b[p] : rvalid_a[p];
                r = d ? rdata_b[p] : rdata_a[p];
                if (v) begin
                    if (q[d*2+p].size() == 0) chk($sformatf("unexpected_rvalid dut%0d p%0d", d, p), 64'd1, 64'd0);
                    else begin
                        e = q[d*2+p].pop_front();
                        chk($sformatf("latency dut%0d p%0d", d, p), 64'(cyc - e.cyc), 64'(d + 1));
                        if (e.chk) chk($sformatf("rdata dut%0d p%0d", d, p), 64'(r), 64'(e.data));
                    end
                end
            end

    task automatic issue(input logic [1:0] eg, input logic [31:0] x, input bit c, input bit pb);
        #1;
        chk("gnt_a", 64'(gnt_a), 64'(eg));
        chk("gnt_b", 64'(gnt_b), 64'(eg));
        for (int p = 0; p < 2; p++)
            if (eg[p]) begin
                q[p].push_back('{cyc, x, c});
                if (pb) q[2+p].push_back('{cyc, x, c});
            end
        @(posedge clk);
    endtask

    task automatic acc(input int p, input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] x, input bit c, input bit pb = 1'b1);
        @(negedge clk);
        req = '0;
        req[p] = 1'b1;
        addr[p] = a;
        we[p] = w;
        wdata[p] = d;
        be[p] = b;
        issue(2'(1 << p), x, c, pb);
    endtask

    task automatic both(input logic [1:0] eg, input logic [31:0] x);
        @(negedge clk);
        req = 2'b11;
        we = '0;
        addr[0] = 12'h010;
        addr[1] = 12'h020;
        issue(eg, x, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req = '0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        @(negedge clk);
        req = 2'b01;
        #1;
        chk("gnt_a_in_reset", 64'(gnt_a), 64'd0);
        chk("gnt_b_in_reset", 64'(gnt_b), 64'd0);
        chk("rvalid_a_reset", 64'(rvalid_a), 64'd0);
        chk("rdata_a_reset", 64'(rdata_a), 64'd0);
        chk("rdata_b_reset", 64'(rdata_b), 64'd0);
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;
        acc(0, 12'h010, 1'b1, 32'h01234567, 4'hF, 32'h0, 1'b0);
        acc(0, 12'h010, 1'b1, 32'hDEADBEEF, 4'hF, 32'h01234567, 1'b1);
        acc(0, 12'h010, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1);
        idle(2);
        @(negedge clk);
        chk("rdata_a_hold", 64'(rdata_a[0]), 64'hDEADBEEF);
        chk("rdata_b_hold", 64'(rdata_b[0]), 64'hDEADBEEF);
        acc(1, 12'h020, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0);
        acc(1, 12'h020, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h11223344, 1'b1);
        acc(1, 12'h020, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b1);
        acc(0, 12'h004, 1'b1, 32'hA1A1A1A1, 4'hF, 32'h0, 1'b0);
        acc(0, 12'h008, 1'b1, 32'hA2A2A2A2, 4'hF, 32'h0, 1'b0);
        acc(0, 12'h00C, 1'b1, 32'hA3A3A3A3, 4'hF, 32'h0, 1'b0);
        acc(0, 12'h004, 1'b0, 32'h0, 4'h0, 32'hA1A1A1A1, 1'b1);
        acc(0, 12'h008, 1'b0, 32'h0, 4'h0, 32'hA2A2A2A2, 1'b1);
        acc(0, 12'h00C, 1'b0, 32'h0, 4'h0, 32'hA3A3A3A3, 1'b1);
        acc(0, 12'h000, 1'b1, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0);
        acc(0, 12'h800, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
        acc(0, 12'h800, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        acc(0, 12'h000, 1'b0, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b1);
        acc(0, 12'h010, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        chk("rvalid_a_midreset", 64'(rvalid_a), 64'd0);
        chk("rvalid_b_midreset", 64'(rvalid_b), 64'd0);
        chk("rdata_a_midreset", 64'(rdata_a), 64'd0);
        chk("rdata_b_midreset", 64'(rdata_b), 64'd0);
        rst_n = 1'b1;
        both(2'b01, 32'hDEADBEEF);
        both(2'b10, 32'h11BB33DD);
        both(2'b01, 32'hDEADBEEF);
        both(2'b10, 32'h11BB33DD);
        idle(4);
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("drain q%0d", i), 64'(q[i].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
